// File: rtl/muldiv.sv
// Iterative 32-bit multiply/divide unit owning HI/LO.
// Shift-add multiply and restoring divide, 32 iterations plus a fix-up cycle.
module muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t state, state_nxt;

  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] mag_a, mag_b;
  logic        is_div, neg_q, neg_r, zero;

  logic        go, mt, fin, sg;
  logic [31:0] a_in, b_in;
  logic [32:0] sum, shl;
  logic [31:0] rdiff;
  logic        ge;
  logic [63:0] prod;
  logic [31:0] quo, rmd;

  // Request decode: mul/div launch and MTHI/MTLO, only from IDLE
  always_comb begin
    go   = start && (state == IDLE) && !op[2];
    mt   = start && (state == IDLE) && op[2] && !op[1];
    sg   = !op[0];
    a_in = (sg && A[31]) ? 32'd0 - A : A;
    b_in = (sg && B[31]) ? 32'd0 - B : B;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = CALC;
      CALC:    if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs
  always_comb begin
    busy = (state != IDLE);
    fin  = (state == FIX);
  end

  // One iteration step and final sign correction
  always_comb begin
    sum   = {1'b0, acc[63:32]}
          + (acc[0] ? {1'b0, mag_a} : 33'd0);
    shl   = {rem, acc[31]};
    ge    = (shl >= {1'b0, mag_b});
    rdiff = shl[31:0] - mag_b;
    prod  = neg_q ? 64'd0 - acc : acc;
    quo   = neg_q ? 32'd0 - acc[31:0] : acc[31:0];
    rmd   = neg_r ? 32'd0 - rem : rem;
  end

  // Datapath, HI/LO and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      rem    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= fin | mt;
      div0 <= fin & is_div & zero;
      if (go) begin
        mag_a  <= a_in;
        mag_b  <= b_in;
        acc    <= {32'd0, op[1] ? a_in : b_in};
        rem    <= '0;
        cnt    <= '0;
        is_div <= op[1];
        neg_q  <= sg & (A[31] ^ B[31]);
        neg_r  <= sg & A[31];
        zero   <= op[1] & (B == 32'd0);
      end else if (mt) begin
        if (op[0]) lo <= A;
        else       hi <= A;
      end else if (state == CALC) begin
        cnt <= cnt + 5'd1;
        if (is_div) begin
          acc[31:0] <= {acc[30:0], ge};
          rem       <= ge ? rdiff : shl[31:0];
        end else begin
          acc <= {sum, acc[31:1]};
        end
      end else if (fin) begin
        if (!is_div) begin
          hi <= prod[63:32];
          lo <= prod[31:0];
        end else if (!zero) begin
          hi <= rmd;
          lo <= quo;
        end
      end
    end
  end

endmodule
